// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the data-memory controller.
//   dmem_state_t  : controller FSM states (IDLE, WAIT, RESP)
//   DMEM_RESET_RD : value of the read-data register after reset
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_RESET_RD = 32'h0000_0000;

endpackage

// File: rtl/riscv_dmem_ram.sv
// riscv_dmem_ram
// Word-organised storage array with per-byte-lane write enables.
// Asynchronous read of the addressed word; the controller registers it.
// Ports:
//   clk  : clock, writes on posedge
//   we   : write enable for this cycle
//   be   : byte-lane enables, bit n covers wd[8n+7:8n]
//   addr : word index
//   wd   : write data
//   rd   : word currently stored at addr
module riscv_dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n]) begin
                    r_mem[addr][8*n +: 8] <= wd[8*n +: 8];
                end
            end
        end
    end

    assign rd = r_mem[addr];

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// riscv_dmem_ctrl
// Data-memory controller: request/ready handshake with a fixed number of
// wait states in front of a byte-lane-writable word array.
// Optional feature macro: DMEM_RANGE_CHECK_EN -- when defined, accesses with
// any address bit above the word-index field set are out of range (writes are
// dropped, reads return zero); when undefined those bits are ignored (alias).
// Ports:
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   mem_req_i   : request, held until mem_ready_o
//   mem_we_i    : 1 = write, 0 = read
//   mem_be_i    : byte-lane write enables
//   mem_addr_i  : byte address
//   mem_wd_i    : write data (lane-replicated)
//   mem_rd_o    : registered read word
//   mem_ready_o : one-cycle completion pulse
module riscv_dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
    output logic        mem_ready_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_t   r_state;
    dmem_state_t   w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [31:0]   r_rd;

    logic          r_we;
    logic [3:0]    r_be;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wd;
    logic          r_oor;

    logic          w_capture;
    logic          w_fire;
    logic          w_ready;
    logic          w_oor_in;
    logic [AW-1:0] w_idx_in;

    logic          w_we_eff;
    logic [3:0]    w_be_eff;
    logic [AW-1:0] w_idx_eff;
    logic [31:0]   w_wd_eff;
    logic          w_oor_eff;
    logic          w_ram_we;
    logic [31:0]   w_ram_rd;

    // Byte-offset bits never matter; upper bits only matter with range check.
    logic          w_unused_addr_bits;
    assign w_unused_addr_bits = ^{mem_addr_i[1:0], mem_addr_i[31:AW+2]};

    assign w_idx_in = mem_addr_i[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [31:0] HI_MASK = ~((32'd1 << (AW + 2)) - 32'd1);
    assign w_oor_in = |(mem_addr_i & HI_MASK);
`else
    assign w_oor_in = 1'b0;
`endif

    // With zero wait states the access fires on the same edge that captures
    // the request, so the live inputs must be used instead of the registers.
    assign w_we_eff  = (r_state == IDLE) ? mem_we_i : r_we;
    assign w_be_eff  = (r_state == IDLE) ? mem_be_i : r_be;
    assign w_idx_eff = (r_state == IDLE) ? w_idx_in : r_idx;
    assign w_wd_eff  = (r_state == IDLE) ? mem_wd_i : r_wd;
    assign w_oor_eff = (r_state == IDLE) ? w_oor_in : r_oor;

    // The array access happens on the edge that enters RESP; a reset on that
    // edge cancels it.
    assign w_ram_we = w_fire & w_we_eff & ~w_oor_eff & ~rst_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_fire      = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req_i) begin
                    w_capture = 1'b1;
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = WS_LOAD;
                    end else begin
                        w_state_nxt = RESP;
                        w_fire      = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                    w_fire      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_ready     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rd    <= DMEM_RESET_RD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_fire && !w_we_eff) begin
                r_rd <= w_oor_eff ? 32'h0000_0000 : w_ram_rd;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_we  <= mem_we_i;
            r_be  <= mem_be_i;
            r_idx <= w_idx_in;
            r_wd  <= mem_wd_i;
            r_oor <= w_oor_in;
        end
    end

    riscv_dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk_i),
        .we   (w_ram_we),
        .be   (w_be_eff),
        .addr (w_idx_eff),
        .wd   (w_wd_eff),
        .rd   (w_ram_rd)
    );

    assign mem_rd_o    = r_rd;
    assign mem_ready_o = w_ready;

endmodule
